// File: rtl/gbt_link_ctrl_pkg.sv
// Shared types for the GBT link controller: clock/reset bundle,
// frame width, idle frame and the link state encoding.
package CKRSPkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

endpackage

package MCPkg;

    localparam int GBT_FRAME_W = 84;
    localparam logic [GBT_FRAME_W-1:0] GBT_IDLE_FRAME = '0;

    typedef enum logic [2:0] {
        NO_SIGNAL   = 3'd0,
        DEBOUNCE    = 3'd1,
        XCVR_RST    = 3'd2,
        WAIT_LOCK   = 3'd3,
        BITSLIP_RST = 3'd4,
        LOCKED      = 3'd5,
        FAILED      = 3'd6
    } gbt_link_state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gbt_link_ctrl_los_debounce.sv
// SFP LOS two-flop synchroniser and low-level debounce counter;
// signal_ok marks the last cycle of a clean debounce window.
module gbt_los_debounce #(
    parameter int DEBOUNCE_CYC = 4000
) (
    input  logic clk,
    input  logic reset,
    input  logic los,
    input  logic en,
    output logic los_sync,
    output logic signal_ok
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          los_meta;
    logic [CW-1:0] cnt;

    // Sync flops reset to "no signal" so nothing starts before LOS is seen low
    always_ff @(posedge clk) begin
        if (reset) begin
            los_meta <= 1'b1;
            los_sync <= 1'b1;
        end else begin
            los_meta <= los;
            los_sync <= los_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !en || los_sync) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign signal_ok = en && !los_sync && (cnt == LAST);

endmodule

// File: rtl/gbt_link_ctrl.sv
// GBT link bring-up/supervision FSM with TX frame gating.
// Define GBT_LINK_STATS_EN to add the saturating lock-loss counter port.
module gbt_link_ctrl
    import CKRSPkg::*, MCPkg::*;
#(
    parameter int LOS_DEBOUNCE_CYC  = 4000,
    parameter int RST_PULSE_CYC     = 16,
    parameter int LOCK_TIMEOUT_CYC  = 400000,
    parameter int UNLOCK_FILTER_CYC = 40,
    parameter int MAX_RETRIES       = 8
) (
    input  ckrs_t                  ClkRs_ix,
    input  logic                   sfp_los_i,
    input  logic                   link_ready_i,
    input  logic                   retry_clear_i,
    input  logic [GBT_FRAME_W-1:0] tx_data_i,
    output logic [GBT_FRAME_W-1:0] tx_data_o,
    output logic                   gbt_reset_o,
    output logic                   bitslip_reset_o,
    output logic                   link_up_o,
    output logic                   failed_o,
`ifdef GBT_LINK_STATS_EN
    output logic [15:0]            lock_loss_cnt_o,
`endif
    output logic [2:0]             state_o,
    output logic [3:0]             retry_cnt_o
);

    localparam int TMAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                               UNLOCK_FILTER_CYC);
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMAX_V      = TW'(TMAX);
    localparam logic [TW-1:0] PULSE_END   = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] UNLOCK_END  = TW'(UNLOCK_FILTER_CYC - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    logic            clk;
    logic            reset;
    logic            los_sync;
    logic            signal_ok;
    logic            deb_en;
    logic [TW-1:0]   tmr;
    logic [3:0]      retry_cnt;
    gbt_link_state_t state;
    gbt_link_state_t state_nxt;

    assign clk    = ClkRs_ix.clk;
    assign reset  = ClkRs_ix.reset;
    assign deb_en = (state == DEBOUNCE);

    gbt_los_debounce #(
        .DEBOUNCE_CYC(LOS_DEBOUNCE_CYC)
    ) u_los (
        .clk      (clk),
        .reset    (reset),
        .los      (sfp_los_i),
        .en       (deb_en),
        .los_sync (los_sync),
        .signal_ok(signal_ok)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            NO_SIGNAL:   if (!los_sync) state_nxt = DEBOUNCE;
            DEBOUNCE:    if (signal_ok) state_nxt = XCVR_RST;
            XCVR_RST:    if (tmr == PULSE_END) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (link_ready_i) begin
                    state_nxt = LOCKED;
                end else if (tmr == TIMEOUT_END) begin
                    state_nxt = (retry_cnt < RETRY_MAX) ? BITSLIP_RST
                                                        : FAILED;
                end
            end
            BITSLIP_RST: if (tmr == PULSE_END) state_nxt = WAIT_LOCK;
            LOCKED: begin
                if (!link_ready_i && tmr == UNLOCK_END) begin
                    state_nxt = XCVR_RST;
                end
            end
            FAILED:      if (retry_clear_i) state_nxt = XCVR_RST;
            default:     state_nxt = NO_SIGNAL;
        endcase
        // Loss of signal overrides every other decision this cycle
        if (los_sync && state != NO_SIGNAL) begin
            state_nxt = NO_SIGNAL;
        end
    end

    // Single phase timer: reloads on entry, in LOCKED it counts low cycles only
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= NO_SIGNAL;
            tmr       <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tmr <= '0;
            end else if (state == LOCKED && link_ready_i) begin
                tmr <= '0;
            end else if (tmr != TMAX_V) begin
                tmr <= tmr + 1'b1;
            end
            if (state == DEBOUNCE && state_nxt == XCVR_RST) begin
                retry_cnt <= '0;
            end else if (state == WAIT_LOCK && state_nxt == BITSLIP_RST) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gbt_reset_o     <= 1'b1;
            bitslip_reset_o <= 1'b0;
            link_up_o       <= 1'b0;
            failed_o        <= 1'b0;
            state_o         <= 3'd0;
            retry_cnt_o     <= '0;
            tx_data_o       <= GBT_IDLE_FRAME;
        end else begin
            gbt_reset_o     <= (state == NO_SIGNAL) || (state == XCVR_RST);
            bitslip_reset_o <= (state == BITSLIP_RST);
            link_up_o       <= (state == LOCKED);
            failed_o        <= (state == FAILED);
            state_o         <= state;
            retry_cnt_o     <= retry_cnt;
            tx_data_o       <= (state == LOCKED) ? tx_data_i : GBT_IDLE_FRAME;
        end
    end

`ifdef GBT_LINK_STATS_EN
    logic [15:0] loss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt        <= '0;
            lock_loss_cnt_o <= '0;
        end else begin
            if (state == LOCKED && state_nxt == XCVR_RST
                && loss_cnt != 16'hFFFF) begin
                loss_cnt <= loss_cnt + 1'b1;
            end
            lock_loss_cnt_o <= loss_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gbt_link_ctrl.sv
// Directed plus randomized bench for gbt_link_ctrl with reduced timing
// parameters; expectations come from the link bring-up rules.
module tb_gbt_link_ctrl;
    import CKRSPkg::*;

    localparam int DEB  = 8;
    localparam int PUL  = 4;
    localparam int TOUT = 50;
    localparam int UNF  = 5;
    localparam int MAXR = 2;

    localparam logic [31:0] S_NOSIG = 0;
    localparam logic [31:0] S_DEB   = 1;
    localparam logic [31:0] S_XRST  = 2;
    localparam logic [31:0] S_WAIT  = 3;
    localparam logic [31:0] S_BSLIP = 4;
    localparam logic [31:0] S_LOCK  = 5;
    localparam logic [31:0] S_FAIL  = 6;

    logic        clk;
    logic        rst;
    ckrs_t       ckrs;
    logic        los;
    logic        link;
    logic        clr;
    logic [83:0] txd;
    logic [83:0] tx_data_o;
    logic        gbt_reset_o;
    logic        bitslip_reset_o;
    logic        link_up_o;
    logic        failed_o;
    logic [2:0]  state_o;
    logic [3:0]  retry_cnt_o;
`ifdef GBT_LINK_STATS_EN
    logic [15:0] lock_loss_cnt_o;
`endif

    int vecs = 0;
    int errs = 0;
    int loss_model = 0;

    assign ckrs.clk   = clk;
    assign ckrs.reset = rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gbt_link_ctrl #(
        .LOS_DEBOUNCE_CYC (DEB),
        .RST_PULSE_CYC    (PUL),
        .LOCK_TIMEOUT_CYC (TOUT),
        .UNLOCK_FILTER_CYC(UNF),
        .MAX_RETRIES      (MAXR)
    ) dut (
        .ClkRs_ix       (ckrs),
        .sfp_los_i      (los),
        .link_ready_i   (link),
        .retry_clear_i  (clr),
        .tx_data_i      (txd),
        .tx_data_o      (tx_data_o),
        .gbt_reset_o    (gbt_reset_o),
        .bitslip_reset_o(bitslip_reset_o),
        .link_up_o      (link_up_o),
        .failed_o       (failed_o),
`ifdef GBT_LINK_STATS_EN
        .lock_loss_cnt_o(lock_loss_cnt_o),
`endif
        .state_o        (state_o),
        .retry_cnt_o    (retry_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk84(input string tag, input logic [83:0] obs,
                         input logic [83:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [83:0] rnd84();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[83:0];
    endfunction

    task automatic wait_state(input logic [31:0] s, input int budget,
                              input string tag);
        int n;
        n = 0;
        while (32'(state_o) !== s && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(state_o), s);
    endtask

    // One-cycle LOS pulse; returns once the FSM reaction is visible on outputs
    task automatic los_glitch();
        los = 1'b1;
        step(1);
        los = 1'b0;
        step(3);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state_o), S_NOSIG);
        chk({tag, "_gbt_reset"}, 32'(gbt_reset_o), 1);
        chk({tag, "_bitslip"}, 32'(bitslip_reset_o), 0);
        chk({tag, "_link_up"}, 32'(link_up_o), 0);
        chk({tag, "_failed"}, 32'(failed_o), 0);
        chk({tag, "_retry"}, 32'(retry_cnt_o), 0);
        chk84({tag, "_tx"}, tx_data_o, 84'h0);
`ifdef GBT_LINK_STATS_EN
        chk({tag, "_loss_cnt"}, 32'(lock_loss_cnt_o), 0);
`endif
    endtask

    initial begin
        int n;
        int pulses;
        int width;
        int drop;
        logic [83:0] exp_tx;

        rst = 1'b1;
        los = 1'b1;
        link = 1'b0;
        clr = 1'b0;
        txd = '0;
        step(3);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            txd = rnd84();
            step(1);
            chk("los_hold_state", 32'(state_o), S_NOSIG);
            chk("los_hold_gbt_reset", 32'(gbt_reset_o), 1);
            chk84("los_hold_tx", tx_data_o, 84'h0);
        end

        los = 1'b0;
        step(3);
        chk("los_latency_early", 32'(state_o), S_NOSIG);
        step(1);
        chk("los_latency", 32'(state_o), S_DEB);
        chk("debounce_gbt_reset", 32'(gbt_reset_o), 0);

        n = 0;
        while (32'(state_o) == S_DEB && n < 50) begin
            step(1);
            n++;
        end
        chk("debounce_len", n, DEB);
        chk("xcvr_entry", 32'(state_o), S_XRST);

        n = 0;
        while (gbt_reset_o && n < 50) begin
            step(1);
            n++;
        end
        chk("gbt_reset_width", n, PUL);
        chk("wait_lock_entry", 32'(state_o), S_WAIT);

        for (int i = 0; i < 19; i++) begin
            txd = rnd84();
            step(1);
            chk84("tx_idle_wait", tx_data_o, 84'h0);
            chk("link_up_wait", 32'(link_up_o), 0);
        end
        link = 1'b1;
        step(1);
        chk("link_up_lat1", 32'(link_up_o), 0);
        step(1);
        chk("link_up_lat2", 32'(link_up_o), 1);
        chk("locked_state", 32'(state_o), S_LOCK);

        txd = 84'h000bebeac1dacdcfffff;
        step(1);
        chk84("tx_fixed", tx_data_o, 84'h000bebeac1dacdcfffff);
        for (int i = 0; i < 16; i++) begin
            exp_tx = rnd84();
            txd = exp_tx;
            step(1);
            chk84("tx_random", tx_data_o, exp_tx);
        end

        // Drops below the filter length must be ignored
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drop = UNF - 1;
            else if (i == 1) drop = UNF;
            else drop = int'($urandom_range(1, 8));
            link = 1'b0;
            step(drop);
            link = 1'b1;
            step(1);
            chk("unlock_filter", 32'(state_o),
                (drop >= UNF) ? S_XRST : S_LOCK);
            if (drop >= UNF) begin
                loss_model++;
                wait_state(S_LOCK, 30, "relock_after_loss");
            end
        end
`ifdef GBT_LINK_STATS_EN
        chk("loss_count", 32'(lock_loss_cnt_o), loss_model);
`endif

        link = 1'b0;
        wait_state(S_WAIT, 40, "drop_to_wait_lock");
        n = 0;
        pulses = 0;
        width = 0;
        while (!failed_o && n < 400) begin
            step(1);
            n++;
            if (bitslip_reset_o) begin
                width++;
            end else if (width != 0) begin
                pulses++;
                chk("bitslip_width", width, PUL);
                width = 0;
            end
        end
        chk("fail_time", n, (MAXR + 1) * TOUT + MAXR * PUL);
        chk("bitslip_pulses", pulses, MAXR);
        chk("fail_retry_cnt", 32'(retry_cnt_o), MAXR);

        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("failed_hold", 32'(failed_o), 1);
            chk("failed_gbt_reset", 32'(gbt_reset_o), 0);
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        chk("clear_to_xcvr", 32'(state_o), S_XRST);
        chk("clear_failed_low", 32'(failed_o), 0);
        link = 1'b1;
        wait_state(S_LOCK, 30, "relock_after_clear");

        txd = rnd84();
        los_glitch();
        chk("los_in_locked", 32'(state_o), S_NOSIG);
        chk("los_in_locked_up", 32'(link_up_o), 0);
        chk84("los_in_locked_tx", tx_data_o, 84'h0);

        link = 1'b0;
        wait_state(S_DEB, 20, "redebounce");
        los_glitch();
        chk("los_in_debounce", 32'(state_o), S_NOSIG);

        wait_state(S_WAIT, 60, "wait_lock_again");
        chk("retry_cleared", 32'(retry_cnt_o), 0);
        wait_state(S_BSLIP, 80, "first_bitslip");
        wait_state(S_WAIT, 20, "second_wait_lock");
        chk("retry_one", 32'(retry_cnt_o), 1);
        // Time the pulse so the synced LOS lands on the timeout cycle
        step(TOUT - 4);
        los_glitch();
        chk("los_at_timeout", 32'(state_o), S_NOSIG);
        chk("los_at_timeout_bs", 32'(bitslip_reset_o), 0);
        chk("los_at_timeout_retry", 32'(retry_cnt_o), 1);
        wait_state(S_XRST, 40, "debounce_done");
        chk("retry_clear_on_debounce", 32'(retry_cnt_o), 0);

        wait_state(S_BSLIP, 100, "bitslip_for_reset");
        rst = 1'b1;
        step(1);
        chk_reset_vals("mid_reset");
        rst = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/gbt_link_ctrl.md
# gbt_link_ctrl

Bring-up and supervision controller for one GBT link on the XU5 design, clocked in the 40 MHz frame-clock domain. It holds the GBT bank in reset until SFP LOS clears and is debounced, then waits for `link_ready` within a timeout. On failure it pulses `bitslip_reset` and retries; after too many failures it latches a failed state. It also gates the 84-bit TX frame so user data is sent only while the link is up.

## Interface
Parameters:
- `LOS_DEBOUNCE_CYC`, 4000: cycles LOS must stay low before bring-up (100 µs at 40 MHz).
- `RST_PULSE_CYC`, 16: width of the `gbt_reset_o` and `bitslip_reset_o` pulses.
- `LOCK_TIMEOUT_CYC`, 400000: cycles allowed for `link_ready_i` to rise (10 ms).
- `UNLOCK_FILTER_CYC`, 40: consecutive low cycles of `link_ready_i` that declare a lock loss.
- `MAX_RETRIES`, 8: bitslip retries before FAILED; range 1..15.

Ports:
- `ClkRs_ix` input `ckrs_t`: `.clk` is the 40 MHz frame clock (the only clock); `.reset` is synchronous, active-high.
- `sfp_los_i` input 1: SFP loss of signal, asynchronous; 2-flop synchronised internally.
- `link_ready_i` input 1: GBT RX link ready.
- `retry_clear_i` input 1: single-cycle pulse that leaves FAILED.
- `tx_data_i` input 84: user TX frame.
- `tx_data_o` output 84: frame to the GBT TX.
- `gbt_reset_o` output 1: GBT bank reset.
- `bitslip_reset_o` output 1: RX bitslip reset.
- `link_up_o` output 1: high in LOCKED.
- `failed_o` output 1: high in FAILED.
- `state_o` output 3: current state encoding.
- `retry_cnt_o` output 4: retries in the current bring-up.
- `lock_loss_cnt_o` output 16: lock losses since reset (present only with `GBT_LINK_STATS_EN`).

## Operation
- Reset values: `gbt_reset_o`=1, `bitslip_reset_o`=0, `link_up_o`=0, `failed_o`=0, `state_o`=NO_SIGNAL(0), `retry_cnt_o`=0, `tx_data_o`=`GBT_IDLE_FRAME`, `lock_loss_cnt_o`=0.
- States: NO_SIGNAL(0), DEBOUNCE(1), XCVR_RST(2), WAIT_LOCK(3), BITSLIP_RST(4), LOCKED(5), FAILED(6).
- NO_SIGNAL: `gbt_reset_o`=1. Moves to DEBOUNCE when synced LOS=0.
- DEBOUNCE: counts cycles with LOS=0. Any LOS=1 sends the FSM to NO_SIGNAL. After `LOS_DEBOUNCE_CYC` cycles: go to XCVR_RST and clear `retry_cnt`.
- XCVR_RST: `gbt_reset_o`=1 for `RST_PULSE_CYC` cycles, then WAIT_LOCK.
- WAIT_LOCK: `gbt_reset_o`=0. `link_ready_i`=1 goes to LOCKED. On timeout:
  - if `retry_cnt`<`MAX_RETRIES`, increment it and go to BITSLIP_RST;
  - otherwise go to FAILED.
- BITSLIP_RST: `bitslip_reset_o`=1 for `RST_PULSE_CYC` cycles, then WAIT_LOCK with the timeout counter restarted.
- LOCKED: `link_up_o`=1 and `tx_data_o`=`tx_data_i`. If `link_ready_i` is low for `UNLOCK_FILTER_CYC` consecutive cycles: increment lock-loss count (saturating) and go to XCVR_RST.
- FAILED: `failed_o`=1, `gbt_reset_o`=0. Leaves on `retry_clear_i` to XCVR_RST.
- Global LOS rule: synced LOS=1 in any state except NO_SIGNAL forces NO_SIGNAL next cycle. This has priority over every other transition, including `retry_clear_i` and a timeout in the same cycle.
- Outside LOCKED, `tx_data_o`=`GBT_IDLE_FRAME` (84'h0).
- Counters never wrap:
  - phase counters reload on every state entry;
  - `lock_loss_cnt` saturates at 16'hFFFF.

## Timing
- All outputs are registered and change on the clock edge after the state transition that causes them.
- `tx_data_o` latency from `tx_data_i` is 1 cycle in LOCKED.
- LOS pin to FSM reaction: 3 cycles (2 synchroniser stages plus 1 state register).
- `link_ready_i` rising in WAIT_LOCK gives `link_up_o`=1 two cycles later.
- Reset asserted mid-operation returns everything to reset values on the next edge.

## Configuration
- `GBT_LINK_STATS_EN` defined: the `lock_loss_cnt_o` port and the 16-bit saturating counter exist.
- `GBT_LINK_STATS_EN` undefined: the port and the counter are absent; FSM behaviour is identical.

## Structure
- `MCPkg` holds `gbt_link_state_t` (3-bit enum), `GBT_IDLE_FRAME` and `GBT_FRAME_W`=84.
- `ckrs_t` comes from `CKRSPkg`.
- One sub-module, `gbt_los_debounce`: LOS synchroniser plus debounce counter, outputting a stable `signal_ok`.

## Test plan
Bench parameters: DEBOUNCE=8, RST_PULSE=4, LOCK_TIMEOUT=50, UNLOCK_FILTER=5, MAX_RETRIES=2.
- Reset, then LOS=1 held: `state_o`=0, `gbt_reset_o`=1, `tx_data_o`=0 throughout.
- LOS falls and `link_ready_i` rises 20 cycles into WAIT_LOCK: the `gbt_reset_o` pulse is exactly 4 cycles; `link_up_o`=1; `tx_data_o`=84'h000bebeac1dacdcfffff one cycle after input.
- `link_ready_i` never rises: exactly 2 `bitslip_reset_o` pulses of 4 cycles; `failed_o`=1 after 3×50 timeout cycles; `retry_clear_i` restarts from XCVR_RST.
- In LOCKED, drop `link_ready_i` for 4 cycles: stays LOCKED. Drop it for 5 cycles: XCVR_RST, and `lock_loss_cnt_o`=1 (stats build).
- LOS pulses to 1 for one cycle during DEBOUNCE, WAIT_LOCK and LOCKED, including a cycle coinciding with the timeout: NO_SIGNAL each time; `retry_cnt_o` clears on the next debounce completion.
- Assert reset during BITSLIP_RST: all outputs at reset values on the next edge.
